// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- what decode sees when IF/ID holds a bubble.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load on enable, clear-to-NOP on clear, hold otherwise.
// A clear keeps the PC fields so decode-side debug still sees the last PC.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcplus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pcplus4_q;
  logic            valid_q;

  // Clear has priority over load so a bubble always wins a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (clr_i) begin
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
    end else if (en_i) begin
      instr_q   <= instr_i;
      pc_q      <= pc_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= 1'b1;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, runs one req/gnt/rvalid transaction at a
// time, and feeds the IF/ID register. Redirects that arrive while a response
// is in flight set Discard so the stale word is dropped when it returns.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusyF
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] buf_q, buf_d;

  logic            load;
  logic            load_from_buf;
  logic            pc_inc;
  logic            ifid_clr;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state decode; redirect and flush override the normal load path.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    buf_d         = buf_q;
    load          = 1'b0;
    load_from_buf = 1'b0;
    pc_inc        = 1'b0;
    case (state_q)
      FS_REQ: begin
        if (ImemGnt) begin
          state_d = FS_WAIT;
          if (PCSrcE) discard_d = 1'b1;
        end
      end
      FS_WAIT: begin
        if (ImemRValid) begin
          if (PCSrcE || discard_q) begin
            discard_d = 1'b0;
            state_d   = FS_REQ;
          end else if (FlushD) begin
            // Flushed response: keep it if decode is stalled, else it is lost.
            if (StallD) begin
              buf_d   = ImemRData;
              state_d = FS_HOLD;
            end else begin
              pc_inc  = 1'b1;
              state_d = FS_REQ;
            end
          end else if (!StallD) begin
            load    = 1'b1;
            pc_inc  = 1'b1;
            state_d = FS_REQ;
          end else begin
            buf_d   = ImemRData;
            state_d = FS_HOLD;
          end
        end else if (PCSrcE) begin
          discard_d = 1'b1;
        end
      end
      FS_HOLD: begin
        if (PCSrcE) begin
          state_d = FS_REQ;
        end else if (!FlushD && !StallD) begin
          load          = 1'b1;
          load_from_buf = 1'b1;
          pc_inc        = 1'b1;
          state_d       = FS_REQ;
        end
      end
      default: state_d = FS_REQ;
    endcase
    if (PCSrcE) pc_d = PCTargetE;
    else if (pc_inc) pc_d = pc_plus4;
  end

  // Fetch control state; the buffer is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FS_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
    buf_q <= buf_d;
  end

  // Any non-stalled cycle without a real load becomes a bubble.
  assign ifid_clr = PCSrcE | FlushD | (~StallD & ~load);

  ifid_reg u_ifid (
    .clk       (clk),
    .reset     (reset),
    .en_i      (load),
    .clr_i     (ifid_clr),
    .instr_i   (load_from_buf ? buf_q : ImemRData),
    .pc_i      (pc_q),
    .pcplus4_i (pc_plus4),
    .instr_o   (InstrD),
    .pc_o      (PCD),
    .pcplus4_o (PCPlus4D),
    .valid_o   (ValidD)
  );

  assign ImemReq    = (state_q == FS_REQ) & ~reset;
  assign ImemAddr   = pc_q;
  assign FetchBusyF = ((state_q == FS_REQ) | (state_q == FS_WAIT)) & ~reset;

endmodule
